uart_tx_frame_scheduler: RTL and testbench

- Shares a single byte-wide UART transmitter between two frame sources:
  - periodic or on-change LED status reports;
  - host-triggered acknowledge frames.
- Sequences each two-byte frame (header, payload) through the transmitter's start/busy handshake.
- Sits between the virtual-interface LED/button logic and the UART TX core, replacing ad-hoc sync timing.

---
 rtl/uart_tx_frame_scheduler.sv | 128 ++++++++++++
 tb/tb_uart_tx_frame_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_scheduler.sv
// Arbitrates status and acknowledge frames onto one byte-wide UART TX core,
// sequencing header then payload through the start/busy handshake.
module uart_tx_frame_scheduler #(
  parameter logic        SEND_ON_CHANGE = 1'b0,
  parameter logic [31:0] CLKS_PER_SYNC  = 32'd1666666,
  parameter logic [7:0]  STATUS_HEADER  = 8'h53,
  parameter logic [7:0]  ACK_HEADER     = 8'h41
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  leds,
  input  logic        ack_req,
  input  logic [7:0]  ack_code,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_active,
  output logic        ack_overflow,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, START, ACCEPT, DRAIN} state_t;

  state_t      state;
  logic        status_pending;
  logic        ack_pending;
  logic        phase;
  logic        src_ack;
  logic [31:0] sync_cnt;
  logic [7:0]  last_sent;
  logic [7:0]  payload;
  logic [7:0]  ack_latched;
  logic        sync_tick;
  logic        grant_ack;
  logic        grant_status;
  logic        change_req;

  assign sync_tick    = (CLKS_PER_SYNC != 32'd0) && (sync_cnt == CLKS_PER_SYNC - 32'd1);
  assign grant_ack    = (state == IDLE) && ack_pending;
  assign grant_status = (state == IDLE) && !ack_pending && status_pending;
  // The grant cycle compares against the snapshot being taken, not the stale last_sent.
  assign change_req   = SEND_ON_CHANGE && (leds != last_sent) && !grant_status;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_cnt <= 32'd0;
    end else if (CLKS_PER_SYNC == 32'd0 || sync_tick) begin
      sync_cnt <= 32'd0;
    end else begin
      sync_cnt <= sync_cnt + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      status_pending <= 1'b0;
      ack_pending    <= 1'b0;
      ack_overflow   <= 1'b0;
    end else begin
      status_pending <= sync_tick | change_req | (status_pending & ~grant_status);
      if (ack_req && ack_pending) ack_overflow <= 1'b1;
      if (grant_ack) ack_pending <= 1'b0;
      else if (ack_req) ack_pending <= 1'b1;
    end
  end

  // Data-only registers: no reset needed, always written before use.
  always_ff @(posedge CLK) begin
    if (ack_req && !ack_pending) ack_latched <= ack_code;
    if (grant_ack) payload <= ack_latched;
    else if (grant_status) payload <= leds;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      frame_active <= 1'b0;
      frames_sent  <= 16'd0;
      phase        <= 1'b0;
      src_ack      <= 1'b0;
      last_sent    <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ack) begin
            src_ack      <= 1'b1;
            phase        <= 1'b0;
            frame_active <= 1'b1;
            state        <= START;
          end else if (grant_status) begin
            src_ack      <= 1'b0;
            phase        <= 1'b0;
            last_sent    <= leds;
            frame_active <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= phase ? payload : (src_ack ? ACK_HEADER : STATUS_HEADER);
            state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (tx_busy) state <= DRAIN;
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (!phase) begin
              phase <= 1'b1;
              state <= START;
            end else begin
              frames_sent  <= frames_sent + 16'd1;
              frame_active <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Directed bench: three scheduler configurations (quiet, periodic P=20, on-change),
// each driving a simple TX core model that stays busy blen cycles per byte.
module tb_uart_tx_frame_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  leds [3];
  logic        ack_req [3];
  logic [7:0]  ack_code [3];
  logic        tx_busy [3];
  logic        tx_start [3];
  logic [7:0]  tx_data [3];
  logic        frame_active [3];
  logic        ack_overflow [3];
  logic [15:0] frames_sent [3];

  int blen [3];
  int busy_cnt [3];
  int start_while_busy [3];
  logic [7:0] log_b [3][16];
  int log_t [3][16];
  int log_n [3];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  code;
    int          blen;
    logic [7:0]  hdr;
    logic [7:0]  pay;
    int          gap;
    logic [15:0] frames;
  } vec_t;
  vec_t vt [5];

  always #5 CLK = ~CLK;

  uart_tx_frame_scheduler #(.SEND_ON_CHANGE(1'b0), .CLKS_PER_SYNC(32'd0)) u_a (
    .CLK(CLK), .RST(RST), .leds(leds[0]), .ack_req(ack_req[0]), .ack_code(ack_code[0]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .frame_active(frame_active[0]), .ack_overflow(ack_overflow[0]), .frames_sent(frames_sent[0]));

  uart_tx_frame_scheduler #(.SEND_ON_CHANGE(1'b0), .CLKS_PER_SYNC(32'd20)) u_b (
    .CLK(CLK), .RST(RST), .leds(leds[1]), .ack_req(ack_req[1]), .ack_code(ack_code[1]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .frame_active(frame_active[1]), .ack_overflow(ack_overflow[1]), .frames_sent(frames_sent[1]));

  uart_tx_frame_scheduler #(.SEND_ON_CHANGE(1'b1), .CLKS_PER_SYNC(32'd0)) u_c (
    .CLK(CLK), .RST(RST), .leds(leds[2]), .ack_req(ack_req[2]), .ack_code(ack_code[2]),
    .tx_busy(tx_busy[2]), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
    .frame_active(frame_active[2]), .ack_overflow(ack_overflow[2]), .frames_sent(frames_sent[2]));

  assign tx_busy[0] = (busy_cnt[0] != 0);
  assign tx_busy[1] = (busy_cnt[1] != 0);
  assign tx_busy[2] = (busy_cnt[2] != 0);

  // TX core model: busy for blen cycles starting the cycle after a strobe.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (tx_start[i] === 1'b1) begin
        if (tx_busy[i]) start_while_busy[i] <= start_while_busy[i] + 1;
        busy_cnt[i] <= blen[i];
      end else if (busy_cnt[i] > 0) begin
        busy_cnt[i] <= busy_cnt[i] - 1;
      end
    end
  end

  // Byte log; entry time is the index of the edge that raised tx_start.
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (RST) begin
        log_n[i] = 0;
      end else if (tx_start[i] === 1'b1 && log_n[i] < 16) begin
        log_b[i][log_n[i]] = tx_data[i];
        log_t[i][log_n[i]] = cyc - 1;
        log_n[i] = log_n[i] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_log(input int i, input int n, input int limit, input string name);
    int k = 0;
    while (log_n[i] < n && k < limit) begin
      tick(1);
      k++;
    end
    check(name, 32'(log_n[i] >= n), 32'd1);
  endtask

  task automatic wait_idle(input int i, input int limit, input string name);
    int k = 0;
    while (frame_active[i] !== 1'b0 && k < limit) begin
      tick(1);
      k++;
    end
    check(name, 32'(frame_active[i]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r0, dev, base;
    logic [7:0] exp_b [6];

    for (int i = 0; i < 3; i++) begin
      leds[i] = 8'h00; ack_req[i] = 1'b0; ack_code[i] = 8'h00; blen[i] = 10;
    end
    vt[0] = '{8'h07, 1,  8'h41, 8'h07, 4,  16'd1};
    vt[1] = '{8'h00, 3,  8'h41, 8'h00, 6,  16'd2};
    vt[2] = '{8'hFF, 10, 8'h41, 8'hFF, 13, 16'd3};
    vt[3] = '{8'h80, 2,  8'h41, 8'h80, 5,  16'd4};
    vt[4] = '{8'h7F, 5,  8'h41, 8'h7F, 8,  16'd5};

    // Reset values and a long quiet stretch with no frame sources enabled
    RST = 1'b1;
    tick(3);
    check("rst_tx_start", 32'(tx_start[0]), 32'd0);
    check("rst_tx_data", 32'(tx_data[0]), 32'h00);
    check("rst_frame_active", 32'(frame_active[0]), 32'd0);
    check("rst_ack_overflow", 32'(ack_overflow[0]), 32'd0);
    check("rst_frames_sent", 32'(frames_sent[0]), 32'd0);
    RST = 1'b0;
    dev = 0;
    repeat (1000) begin
      tick(1);
      if (tx_start[0] !== 1'b0 || tx_data[0] !== 8'h00 || frame_active[0] !== 1'b0 ||
          ack_overflow[0] !== 1'b0 || frames_sent[0] !== 16'd0) dev++;
    end
    check("idle_deviations", 32'(dev), 32'd0);
    check("idle_no_bytes", 32'(log_n[0]), 32'd0);

    // Table-driven acknowledge frames with varying TX busy lengths
    for (int v = 0; v < 5; v++) begin
      base = log_n[0];
      blen[0] = vt[v].blen;
      ack_code[0] = vt[v].code;
      ack_req[0] = 1'b1;
      n = cyc;
      tick(1);
      ack_req[0] = 1'b0;
      ack_code[0] = ~vt[v].code;
      wait_log(0, base + 2, 100, "vec_bytes_timeout");
      wait_idle(0, 100, "vec_idle_timeout");
      check("vec_header", 32'(log_b[0][base]), 32'(vt[v].hdr));
      check("vec_payload", 32'(log_b[0][base + 1]), 32'(vt[v].pay));
      check("vec_ack_latency", 32'(log_t[0][base] - n), 32'd2);
      check("vec_byte_gap", 32'(log_t[0][base + 1] - log_t[0][base]), 32'(vt[v].gap));
      check("vec_frames_sent", 32'(frames_sent[0]), 32'(vt[v].frames));
      tick(2);
    end
    check("vec_no_overflow", 32'(ack_overflow[0]), 32'd0);

    // Reset while the header byte sits in ACCEPT
    blen[0] = 10;
    ack_code[0] = 8'h22;
    ack_req[0] = 1'b1;
    tick(1);
    ack_req[0] = 1'b0;
    tick(2);
    check("mid_header_strobe", 32'(tx_start[0]), 32'd1);
    check("mid_frames_before", 32'(frames_sent[0]), 32'd5);
    RST = 1'b1;
    tick(1);
    check("mid_frame_active", 32'(frame_active[0]), 32'd0);
    check("mid_tx_start", 32'(tx_start[0]), 32'd0);
    check("mid_tx_data", 32'(tx_data[0]), 32'h00);
    check("mid_frames_sent", 32'(frames_sent[0]), 32'd0);
    RST = 1'b0;
    tick(1);
    check("mid_no_strobe_after", 32'(tx_start[0]), 32'd0);
    tick(40);
    check("mid_no_payload", 32'(log_n[0]), 32'd0);

    // Second ack_req lands in the grant cycle and is dropped
    blen[0] = 3;
    ack_code[0] = 8'h11;
    ack_req[0] = 1'b1;
    tick(1);
    check("ovf_not_granted_yet", 32'(frame_active[0]), 32'd0);
    ack_code[0] = 8'h99;
    tick(1);
    ack_req[0] = 1'b0;
    check("ovf_frame_active", 32'(frame_active[0]), 32'd1);
    check("ovf_flag_set", 32'(ack_overflow[0]), 32'd1);
    wait_log(0, 2, 100, "ovf_bytes_timeout");
    wait_idle(0, 100, "ovf_idle_timeout");
    tick(30);
    check("ovf_one_frame", 32'(log_n[0]), 32'd2);
    check("ovf_header", 32'(log_b[0][0]), 32'h41);
    check("ovf_first_code", 32'(log_b[0][1]), 32'h11);
    check("ovf_frames_sent", 32'(frames_sent[0]), 32'd1);
    check("ovf_sticky", 32'(ack_overflow[0]), 32'd1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check("ovf_cleared", 32'(ack_overflow[0]), 32'd0);

    // Periodic status frames, P=20; tick on edge 19, grant 20, header strobe 21
    RST = 1'b1;
    leds[1] = 8'hA5;
    blen[1] = 10;
    tick(3);
    RST = 1'b0;
    r0 = cyc;
    wait_log(1, 6, 300, "per_bytes_timeout");
    for (int k = 0; k < 6; k++) exp_b[k] = (k % 2 == 0) ? 8'h53 : 8'hA5;
    for (int k = 0; k < 6; k++) check("per_byte", 32'(log_b[1][k]), 32'(exp_b[k]));
    check("per_first_start", 32'(log_t[1][0] - r0), 32'd21);
    check("per_payload_gap", 32'(log_t[1][1] - log_t[1][0]), 32'd13);
    check("per_frame_spacing", 32'(log_t[1][2] - log_t[1][0]), 32'd27);
    check("per_frames_mid", 32'(frames_sent[1]), 32'd2);
    wait_idle(1, 100, "per_idle_timeout");
    check("per_frames_3", 32'(frames_sent[1]), 32'd3);

    // Ack request on the same edge as the sync tick: ack frame goes first
    RST = 1'b1;
    leds[1] = 8'h5A;
    tick(3);
    RST = 1'b0;
    r0 = cyc;
    tick(19);
    ack_code[1] = 8'h07;
    ack_req[1] = 1'b1;
    tick(1);
    ack_req[1] = 1'b0;
    wait_log(1, 4, 200, "pri_bytes_timeout");
    exp_b[0] = 8'h41; exp_b[1] = 8'h07; exp_b[2] = 8'h53; exp_b[3] = 8'h5A;
    for (int k = 0; k < 4; k++) check("pri_byte", 32'(log_b[1][k]), 32'(exp_b[k]));
    check("pri_ack_latency", 32'(log_t[1][0] - (r0 + 19)), 32'd2);
    check("pri_back_to_back", 32'(log_t[1][2] - log_t[1][1]), 32'd14);
    wait_idle(1, 100, "pri_idle_timeout");
    check("pri_frames_sent", 32'(frames_sent[1]), 32'd2);

    // On-change frames with payload snapshot
    RST = 1'b1;
    leds[2] = 8'h00;
    blen[2] = 10;
    tick(3);
    RST = 1'b0;
    tick(5);
    check("chg_quiet_start", 32'(log_n[2]), 32'd0);
    leds[2] = 8'h3C;
    wait_log(2, 1, 50, "chg_first_timeout");
    leds[2] = 8'h3D;
    wait_log(2, 4, 200, "chg_second_timeout");
    tick(100);
    check("chg_byte_count", 32'(log_n[2]), 32'd4);
    exp_b[0] = 8'h53; exp_b[1] = 8'h3C; exp_b[2] = 8'h53; exp_b[3] = 8'h3D;
    for (int k = 0; k < 4; k++) check("chg_byte", 32'(log_b[2][k]), 32'(exp_b[k]));
    check("chg_frames_sent", 32'(frames_sent[2]), 32'd2);

    for (int i = 0; i < 3; i++) check("start_while_busy", 32'(start_while_busy[i]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
